// File: rtl/conv_pkg.sv
// Shared definitions for the padding and 3x3 convolution stream blocks:
// geometry derivation helpers and the common two-state control enumeration.
package conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } conv_state_t;

    function automatic int calc_tpp(input int channels, input int width, input int word_width);
        return channels / (width / word_width);
    endfunction

    function automatic int calc_out_dim(input int in_dim, input int pad);
        return in_dim + 2 * pad;
    endfunction

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zero_pad_2d.sv
// Zero-border padder for a raster-order AXI4-stream image, placed directly in
// front of the 3x3 convolution so that the convolution output keeps the input size.
module zero_pad_2d
    import conv_pkg::*;
#(
    parameter int IN_HEIGHT  = 4,
    parameter int IN_WIDTH   = 4,
    parameter int IN_CHANNEL = 2,
    parameter int WIDTH      = 8,
    parameter int WORD_WIDTH = 8,
    parameter int PAD        = 1
) (
    input  logic             i_aclk,
    input  logic             i_aresetn,
    input  logic             i_tvalid,
    output logic             o_tready,
    input  logic [WIDTH-1:0] i_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast
);

    localparam int TPP   = calc_tpp(IN_CHANNEL, WIDTH, WORD_WIDTH);
    localparam int OUT_H = calc_out_dim(IN_HEIGHT, PAD);
    localparam int OUT_W = calc_out_dim(IN_WIDTH, PAD);
    localparam int RW    = cnt_width(OUT_H);
    localparam int CW    = cnt_width(OUT_W);
    localparam int BW    = cnt_width(TPP);

    localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI   = RW'(PAD + IN_HEIGHT);
    localparam logic [RW-1:0] ROW_MAX  = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(PAD);
    localparam logic [CW-1:0] COL_HI   = CW'(PAD + IN_WIDTH);
    localparam logic [CW-1:0] COL_MAX  = CW'(OUT_W - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(TPP - 1);

    conv_state_t   state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [BW-1:0] beat;

    logic interior;
    logic can_load;
    logic load;
    logic last_pos;

    // Position classification and output-register load decision for the next beat.
    always_comb begin
        interior = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
        can_load = (state == EMIT) && (!o_tvalid || i_tready);
        load     = can_load && (!interior || i_tvalid);
        last_pos = (row == ROW_MAX) && (col == COL_MAX) && (beat == BEAT_MAX);
    end

    // Upstream is only asked for data at interior positions, never gated by i_tvalid.
    assign o_tready = can_load && interior;

    // Control FSM, position counters and registered output beat.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            beat     <= '0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The last beat of the previous frame may still be draining here.
                    if (i_tready) begin
                        o_tvalid <= 1'b0;
                    end
                    if (i_tvalid) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (load) begin
                        o_tvalid <= 1'b1;
                        o_tdata  <= interior ? i_tdata : {WIDTH{1'b0}};
                        o_tlast  <= last_pos;
                        if (beat == BEAT_MAX) begin
                            beat <= '0;
                            if (col == COL_MAX) begin
                                col <= '0;
                                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end else begin
                            beat <= beat + BW'(1);
                        end
                        if (last_pos) begin
                            state <= IDLE;
                        end
                    end else if (i_tready) begin
                        // Upstream stall: let the pending beat drain rather than fill in a zero.
                        o_tvalid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_pad_2d.sv
// Self-checking bench for zero_pad_2d: table-driven scenarios with random
// handshakes against a pixel-level padding model, plus reset and idle sequences.
module tb_zero_pad_2d;

    localparam int IH  = 2;
    localparam int IW  = 2;
    localparam int IC  = 2;
    localparam int W   = 8;
    localparam int WW  = 8;
    localparam int P   = 1;
    localparam int TPP = IC / (W / WW);
    localparam int OH  = IH + 2 * P;
    localparam int OW  = IW + 2 * P;
    localparam int FRAME_IN  = IH * IW * TPP;
    localparam int FRAME_OUT = OH * OW * TPP;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_tvalid;
    logic         o_tready;
    logic [W-1:0] i_tdata;
    logic         o_tvalid;
    logic         i_tready;
    logic [W-1:0] o_tdata;
    logic         o_tlast;

    zero_pad_2d #(
        .IN_HEIGHT (IH),
        .IN_WIDTH  (IW),
        .IN_CHANNEL(IC),
        .WIDTH     (W),
        .WORD_WIDTH(WW),
        .PAD       (P)
    ) dut (
        .i_aclk   (clk),
        .i_aresetn(rst_n),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .i_tdata  (i_tdata),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] in_q[$];
    logic [W-1:0] exp_data[$];
    logic         exp_last[$];
    logic [W-1:0] out_data[$];
    logic         out_last[$];

    typedef struct {
        string name;
        int    frames;
        int    ready_mode;   // 0 always ready, 1 toggling 1,0, 2 random
        int    valid_mode;   // 0 always valid, 1 three-cycle gap before input beat 3, 2 random
        bit    rand_data;
        int    exp_beats;
        int    exp_lasts;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Padding model: walk the output image pixel by pixel and fetch the source pixel or zero.
    task automatic build_expected(input int frames);
        exp_data.delete();
        exp_last.delete();
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++)
                    for (int b = 0; b < TPP; b++) begin
                        if (r >= P && r < P + IH && c >= P && c < P + IW)
                            exp_data.push_back(in_q[f * FRAME_IN + ((r - P) * IW + (c - P)) * TPP + b]);
                        else
                            exp_data.push_back('0);
                        exp_last.push_back(r == OH - 1 && c == OW - 1 && b == TPP - 1);
                    end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        i_tvalid = 1'b0;
        i_tready = 1'b0;
        i_tdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_tvalid", o_tvalid, 1'b0);
        check("reset_tdata", o_tdata, '0);
        check("reset_tlast", o_tlast, 1'b0);
        check("reset_tready", o_tready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive in_q upstream and collect output beats until stop_after beats have transferred.
    task automatic run(input int ready_mode, input int valid_mode, input int stop_after,
                       output bit timed_out);
        int           idx = 0;
        int           gap_left = 3;
        int           cyc = 0;
        bit           holding = 1'b0;
        bit           prev_stall = 1'b0;
        logic [W-1:0] prev_d = '0;
        logic         prev_l = 1'b0;
        out_data.delete();
        out_last.delete();
        timed_out = 1'b0;
        while (out_data.size() < stop_after) begin
            if (cyc > 2000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       i_tready = 1'b1;
                1:       i_tready = (cyc % 2) == 1;
                2:       i_tready = $urandom_range(0, 3) != 0;
                default: i_tready = 1'b1;
            endcase
            if (idx >= in_q.size()) i_tvalid = 1'b0;
            else if (holding) i_tvalid = 1'b1;
            else begin
                case (valid_mode)
                    1: begin
                        if (idx == 2 && gap_left > 0) begin
                            gap_left--;
                            i_tvalid = 1'b0;
                        end else i_tvalid = 1'b1;
                    end
                    2:       i_tvalid = $urandom_range(0, 2) != 0;
                    default: i_tvalid = 1'b1;
                endcase
            end
            i_tdata = i_tvalid ? in_q[idx] : W'($urandom);
            #1;
            if (prev_stall) begin
                check("stall_tvalid", o_tvalid, 1'b1);
                check("stall_tdata", o_tdata, prev_d);
                check("stall_tlast", o_tlast, prev_l);
            end
            prev_stall = o_tvalid && !i_tready;
            prev_d = o_tdata;
            prev_l = o_tlast;
            if (i_tvalid && o_tready) begin
                idx++;
                holding = 1'b0;
            end else holding = i_tvalid;
            if (o_tvalid && i_tready) begin
                out_data.push_back(o_tdata);
                out_last.push_back(o_tlast);
            end
        end
    endtask

    task automatic compare_beats(input string tag, input int n);
        check({tag, "_count"}, out_data.size() >= n, 1'b1);
        for (int i = 0; i < n && i < out_data.size(); i++) begin
            check({tag, "_data"}, out_data[i], exp_data[i]);
            check({tag, "_last"}, out_last[i], exp_last[i]);
        end
    endtask

    task automatic load_seq(input int frames);
        in_q.delete();
        for (int i = 0; i < frames * FRAME_IN; i++) in_q.push_back(W'(i + 1));
    endtask

    initial begin
        bit timed_out;
        int lasts;

        vecs[0] = '{"basic",        1, 0, 0, 1'b0, 32, 1};
        vecs[1] = '{"backpressure", 1, 1, 0, 1'b0, 32, 1};
        vecs[2] = '{"upstream_gap", 1, 0, 1, 1'b0, 32, 1};
        vecs[3] = '{"back_to_back", 2, 0, 0, 1'b0, 64, 2};
        vecs[4] = '{"rand_a",       2, 2, 2, 1'b1, 64, 2};
        vecs[5] = '{"rand_b",       3, 2, 2, 1'b1, 96, 3};
        vecs[6] = '{"rand_c",       1, 1, 2, 1'b1, 32, 1};

        do_reset();

        // Idle hold: no upstream activity means no output and no ready.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_tvalid = 1'b0;
            i_tready = $urandom_range(0, 1);
            #1;
            check("idle_hold", {o_tvalid, o_tready}, 2'b00);
        end

        for (int v = 0; v < 7; v++) begin
            do_reset();
            if (vecs[v].rand_data) begin
                in_q.delete();
                for (int i = 0; i < vecs[v].frames * FRAME_IN; i++) in_q.push_back(W'($urandom));
            end else load_seq(vecs[v].frames);
            build_expected(vecs[v].frames);
            check({vecs[v].name, "_model_len"}, exp_data.size(), vecs[v].exp_beats);
            run(vecs[v].ready_mode, vecs[v].valid_mode, vecs[v].exp_beats, timed_out);
            check({vecs[v].name, "_timeout"}, timed_out, 1'b0);
            compare_beats(vecs[v].name, vecs[v].exp_beats);
            lasts = 0;
            foreach (out_last[i]) lasts += int'(out_last[i]);
            check({vecs[v].name, "_tlast_pulses"}, lasts, vecs[v].exp_lasts);
            if (v == 0 && out_data.size() >= 32) begin
                check("basic_beat10", out_data[10], 8'd1);
                check("basic_beat18", out_data[18], 8'd5);
                check("basic_beat31_last", out_last[31], 1'b1);
            end
            // After the final beat transfers the block returns to idle and drains.
            @(negedge clk);
            i_tvalid = 1'b0;
            i_tready = 1'b1;
            #1;
            check({vecs[v].name, "_drained"}, {o_tvalid, o_tready}, 2'b00);
        end

        // Mid-frame reset after output beat 12, then a clean basic frame.
        do_reset();
        load_seq(1);
        build_expected(1);
        run(0, 0, 13, timed_out);
        check("midreset_timeout", timed_out, 1'b0);
        compare_beats("midreset_prefix", 13);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        i_tvalid = 1'b0;
        #1;
        check("midreset_tvalid", o_tvalid, 1'b0);
        check("midreset_tready", o_tready, 1'b0);
        check("midreset_tdata", o_tdata, '0);
        check("midreset_tlast", o_tlast, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 0, 32, timed_out);
        check("after_reset_timeout", timed_out, 1'b0);
        compare_beats("after_reset", 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
